circuit_breaker_ctrl: RTL and testbench
=======================================

Name: circuit_breaker_ctrl

Overview:
- Trading-halt controller that sits downstream of the 8-detector anomaly block and upstream of the order book.
- Applies a per-detector mask to the detector alert bitmap and requires alerts to persist before acting. Flash-crash and manual requests halt immediately.
- Sequences NORMAL/WATCH/HALT/COOLDOWN, gates order matching via trade_enable, and reports each halt cause on a valid/ready event port.

Parameters:
- PERSIST, 3, consecutive cycles of non-critical masked alert needed to halt; legal range 2..15.
- COOLDOWN, 1000, cycles spent in COOLDOWN before trading resumes; legal range 1..65535.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- alert_bitmap  in  8  detector flags; bit7 = flash crash (critical)
- alert_mask  in  8  config; 1 = ignore that detector
- halt_req  in  1  manual halt request (level)
- ack  in  1  operator acknowledge/clear (single-cycle pulse or level)
- trade_enable  out  1  1 = order book may match
- halt  out  1  1 while in HALT
- state  out  2  0 = NORMAL, 1 = WATCH, 2 = HALT, 3 = COOLDOWN
- sticky_bitmap  out  8  accumulated masked alerts since last ack
- halt_count  out  8  saturating count of HALT entries
- event_valid  out  1  halt-cause event available
- event_code  out  4  bit3 = manual, bits2:0 = highest masked alert index
- event_ready  in  1  consumer accepts event
- event_overflow  out  1  an event was dropped

Behaviour:
- All outputs are registered. Reset gives: state NORMAL, trade_enable 1, halt 0, sticky 0, halt_count 0, event_valid 0, event_code 0, event_overflow 0, persist counter 0, cooldown timer 0.
- Reset asserted mid-operation aborts any state immediately.
- Definitions:
  - m = alert_bitmap & ~alert_mask.
  - crit = m[7].
  - top = index of the highest set bit of m, or 0 if m == 0.
- Trigger priority, evaluated every cycle: halt_req > crit > persistence.
- NORMAL:
  - halt_req or crit -> HALT next cycle.
  - Otherwise, if m != 0 -> WATCH with persist counter = 1.
- WATCH:
  - halt_req or crit -> HALT.
  - m == 0 -> NORMAL, counter cleared.
  - Otherwise the counter increments. When the incremented value equals PERSIST -> HALT.
  - Net effect: HALT is entered the cycle after the PERSIST-th consecutive cycle with m != 0.
- HALT:
  - Exits to COOLDOWN when ack == 1, m == 0 and halt_req == 0 in the same cycle; the timer loads COOLDOWN.
  - An ack while alerts are still present does not exit.
- COOLDOWN:
  - halt_req or crit -> HALT (counted as a new HALT entry).
  - m != 0 (non-critical) reloads the timer to COOLDOWN.
  - Otherwise the timer decrements. When timer == 1 and there is no retrigger -> NORMAL.
  - Net effect: exactly COOLDOWN quiet cycles are spent in COOLDOWN.
- trade_enable = 1 in NORMAL and WATCH, 0 in HALT and COOLDOWN.
- halt = 1 only in HALT.
- Outputs change on the same edge as state.
- HALT entry effects, applied on the entry edge:
  - halt_count increments, saturating at 255.
  - An event is generated: code = {halt_req, top} sampled in the trigger cycle.
- Event port:
  - event_valid stays high until a cycle with event_ready == 1.
  - If a new event arrives while event_valid && !event_ready, the old event is kept, the new one is dropped, and event_overflow is set.
  - If a new event arrives in the same cycle as event_ready == 1, the new event is loaded and event_valid stays 1.
  - event_code is stable while valid.
- sticky_bitmap:
  - Normally updates to sticky | m each cycle.
  - On an ack cycle it updates to m: the clear wins, but current alerts are still captured.
  - ack also clears event_overflow, in any state.
- halt_req held high keeps the block in HALT regardless of ack.
- alert_mask changes take effect on the same cycle.

Test Plan:
- Reset: rst_n = 0 mid-HALT -> state 0, trade_enable 1, halt_count 0, event_valid 0 asynchronously.
- Persistence: bitmap 0x04 for 2 cycles then 0 -> WATCH then NORMAL, no halt. Bitmap 0x04 for 3 cycles -> state 2 on cycle 4, event_code 0x2, halt_count 1.
- Flash crash and masking:
  - Bitmap 0x81 for 1 cycle -> HALT next cycle, event_code 0x7.
  - Same stimulus with alert_mask 0x80 -> WATCH only; event_code 0x0 if it later persists.
- Exit and cooldown (COOLDOWN = 5):
  - In HALT with m = 0, ack pulse -> COOLDOWN; NORMAL after exactly 5 cycles; trade_enable 0 throughout.
  - Bitmap 0x02 at cooldown cycle 3 -> timer reloads, 5 more cycles needed.
  - Bitmap 0x80 during cooldown -> HALT, halt_count +1.
- Manual and events:
  - halt_req with event_ready = 0 -> event_code 0x8 held valid.
  - Second halt (via cooldown retrigger) -> event_overflow = 1, code stays 0x8.
  - ack clears the overflow.
  - event_ready = 1 coincident with a new event -> new code loaded.
- Saturation: 300 HALT/COOLDOWN cycles (COOLDOWN = 1) -> halt_count stops at 255.

Source files
------------

// File: rtl/circuit_breaker_ctrl_if.sv
// Purpose: bundles the alert inputs, operator controls, trading-gate outputs
//          and the halt-cause event port of circuit_breaker_ctrl.
// Ports  : master = alert source / operator / event consumer side,
//          slave  = the breaker controller itself.
interface circuit_breaker_ctrl_if;
    logic [7:0] alert_bitmap;    // detector flags, bit7 = flash crash
    logic [7:0] alert_mask;      // 1 = ignore that detector
    logic       halt_req;        // manual halt request (level)
    logic       ack;             // operator acknowledge / clear
    logic       event_ready;     // consumer accepts event
    logic       trade_enable;    // 1 = order book may match
    logic       halt;            // 1 while halted
    logic [1:0] state;           // 0 NORMAL, 1 WATCH, 2 HALT, 3 COOLDOWN
    logic [7:0] sticky_bitmap;   // masked alerts accumulated since last ack
    logic [7:0] halt_count;      // saturating halt-entry count
    logic       event_valid;     // halt-cause event available
    logic [3:0] event_code;      // {manual, highest masked alert index}
    logic       event_overflow;  // an event was dropped

    modport master (
        output alert_bitmap, alert_mask, halt_req, ack, event_ready,
        input  trade_enable, halt, state, sticky_bitmap, halt_count,
               event_valid, event_code, event_overflow
    );

    modport slave (
        input  alert_bitmap, alert_mask, halt_req, ack, event_ready,
        output trade_enable, halt, state, sticky_bitmap, halt_count,
               event_valid, event_code, event_overflow
    );
endinterface

// File: rtl/circuit_breaker_ctrl.sv
// Purpose: trading-halt sequencer (NORMAL/WATCH/HALT/COOLDOWN) with alert masking and persistence.
// Latency: every output is registered; a trigger seen in cycle N is visible after edge N.
// Backpressure: one-deep event register held until event_ready; events arriving while blocked are dropped and flagged.
// Ports: clk, rst_n (async active-low); bus = circuit_breaker_ctrl_if.slave carrying alerts,
//        mask, halt_req, ack, event_ready in and trade_enable, halt, state, sticky_bitmap,
//        halt_count, event_valid/event_code/event_overflow out.
module circuit_breaker_ctrl #(
    parameter int unsigned PERSIST  = 3,
    parameter int unsigned COOLDOWN = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    circuit_breaker_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_WATCH    = 2'd1,
        ST_HALT     = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_e;

    localparam logic [3:0]  PERSIST_C  = 4'(PERSIST);
    localparam logic [15:0] COOLDOWN_C = 16'(COOLDOWN);

    state_e      state_q, state_d;
    logic [3:0]  persist_q, persist_d;
    logic [15:0] timer_q, timer_d;
    logic        trade_enable_q, trade_enable_d;
    logic        halt_q, halt_d;
    logic [7:0]  sticky_q, sticky_d;
    logic [7:0]  halt_count_q, halt_count_d;
    logic        event_valid_q, event_valid_d;
    logic [3:0]  event_code_q, event_code_d;
    logic        event_overflow_q, event_overflow_d;

    logic [7:0]  m;
    logic        crit;
    logic        trig_now;
    logic [2:0]  top;
    logic        halt_entry;

    assign m        = bus.alert_bitmap & ~bus.alert_mask;
    assign crit     = m[7];
    assign trig_now = bus.halt_req | crit;

    // Highest set index of the masked alerts; lower bits are overwritten by higher ones.
    always_comb begin
        top = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) top = 3'(i);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_NORMAL;
            persist_q        <= 4'd0;
            timer_q          <= 16'd0;
            trade_enable_q   <= 1'b1;
            halt_q           <= 1'b0;
            sticky_q         <= 8'd0;
            halt_count_q     <= 8'd0;
            event_valid_q    <= 1'b0;
            event_code_q     <= 4'd0;
            event_overflow_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            persist_q        <= persist_d;
            timer_q          <= timer_d;
            trade_enable_q   <= trade_enable_d;
            halt_q           <= halt_d;
            sticky_q         <= sticky_d;
            halt_count_q     <= halt_count_d;
            event_valid_q    <= event_valid_d;
            event_code_q     <= event_code_d;
            event_overflow_q <= event_overflow_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        persist_d  = persist_q;
        timer_d    = timer_q;
        halt_entry = 1'b0;
        case (state_q)
            ST_NORMAL: begin
                if (trig_now) begin
                    halt_entry = 1'b1;
                end else if (m != 8'd0) begin
                    state_d   = ST_WATCH;
                    persist_d = 4'd1;
                end
            end
            ST_WATCH: begin
                if (trig_now) begin
                    halt_entry = 1'b1;
                end else if (m == 8'd0) begin
                    state_d   = ST_NORMAL;
                    persist_d = 4'd0;
                end else if (persist_q + 4'd1 == PERSIST_C) begin
                    halt_entry = 1'b1;
                end else begin
                    persist_d = persist_q + 4'd1;
                end
            end
            ST_HALT: begin
                // Only a clean ack (no alerts, no manual hold) releases the halt.
                if (bus.ack && (m == 8'd0) && !bus.halt_req) begin
                    state_d = ST_COOLDOWN;
                    timer_d = COOLDOWN_C;
                end
            end
            ST_COOLDOWN: begin
                if (trig_now) begin
                    halt_entry = 1'b1;
                end else if (m != 8'd0) begin
                    timer_d = COOLDOWN_C;
                end else if (timer_q == 16'd1) begin
                    state_d = ST_NORMAL;
                    timer_d = 16'd0;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: state_d = ST_NORMAL;
        endcase
        if (halt_entry) begin
            state_d   = ST_HALT;
            persist_d = 4'd0;
            timer_d   = 16'd0;
        end
    end

    // Output logic: registered outputs follow the next state so they move with it.
    always_comb begin
        trade_enable_d = (state_d == ST_NORMAL) || (state_d == ST_WATCH);
        halt_d         = (state_d == ST_HALT);
        sticky_d       = bus.ack ? m : (sticky_q | m);
        halt_count_d   = halt_count_q;
        if (halt_entry && (halt_count_q != 8'hFF)) halt_count_d = halt_count_q + 8'd1;

        event_valid_d    = event_valid_q;
        event_code_d     = event_code_q;
        event_overflow_d = event_overflow_q & ~bus.ack;
        if (halt_entry) begin
            if (event_valid_q && !bus.event_ready) begin
                // Oldest cause is kept; a drop set in the same cycle as ack stays visible.
                event_overflow_d = 1'b1;
            end else begin
                event_valid_d = 1'b1;
                event_code_d  = {bus.halt_req, top};
            end
        end else if (bus.event_ready) begin
            event_valid_d = 1'b0;
        end
    end

    assign bus.state          = state_q;
    assign bus.trade_enable   = trade_enable_q;
    assign bus.halt           = halt_q;
    assign bus.sticky_bitmap  = sticky_q;
    assign bus.halt_count     = halt_count_q;
    assign bus.event_valid    = event_valid_q;
    assign bus.event_code     = event_code_q;
    assign bus.event_overflow = event_overflow_q;

endmodule

// File: tb/tb_circuit_breaker_ctrl.sv
module tb_circuit_breaker_ctrl;
    localparam int PERSIST  = 3;
    localparam int COOLDOWN = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int tests_run    = 0;
    int tests_failed = 0;

    circuit_breaker_ctrl_if bus ();

    circuit_breaker_ctrl #(.PERSIST(PERSIST), .COOLDOWN(COOLDOWN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: mode, length of the current alert run, quiet cycles seen in cooldown.
    int         md_mode;    // 0 NORMAL, 1 WATCH, 2 HALT, 3 COOLDOWN
    int         md_run;
    int         md_quiet;
    int         md_count;
    logic       md_valid;
    logic [3:0] md_code;
    logic       md_ovf;
    logic [7:0] md_sticky;

    function automatic int highest(input logic [7:0] v);
        int h = 0;
        for (int i = 0; i < 8; i++) if (v[i]) h = i;
        return h;
    endfunction

    task automatic model_reset();
        md_mode = 0; md_run = 0; md_quiet = 0; md_count = 0;
        md_valid = 1'b0; md_code = 4'd0; md_ovf = 1'b0; md_sticky = 8'd0;
    endtask

    task automatic model_step();
        logic [7:0] m;
        bit enter;
        bit old_valid;
        m = bus.alert_bitmap & ~bus.alert_mask;
        enter = 0;
        old_valid = md_valid;
        if (md_mode == 0 || md_mode == 1) begin
            if (bus.halt_req || m[7]) enter = 1;
            else if (m != 0) begin
                md_run++;
                if (md_run >= PERSIST) enter = 1; else md_mode = 1;
            end else begin
                md_run = 0; md_mode = 0;
            end
        end else if (md_mode == 2) begin
            if (bus.ack && m == 0 && !bus.halt_req) begin md_mode = 3; md_quiet = 0; end
        end else begin
            if (bus.halt_req || m[7]) enter = 1;
            else if (m != 0) md_quiet = 0;
            else begin
                md_quiet++;
                if (md_quiet == COOLDOWN) md_mode = 0;
            end
        end
        if (bus.ack) md_ovf = 1'b0;
        if (enter) begin
            md_mode = 2; md_run = 0;
            if (md_count < 255) md_count++;
            if (old_valid && !bus.event_ready) md_ovf = 1'b1;
            else begin md_valid = 1'b1; md_code = {bus.halt_req, 3'(highest(m))}; end
        end else if (bus.event_ready) md_valid = 1'b0;
        md_sticky = bus.ack ? m : (md_sticky | m);
    endtask

    function automatic logic [25:0] obs();
        return {bus.state, bus.trade_enable, bus.halt, bus.sticky_bitmap, bus.halt_count,
                bus.event_valid, bus.event_code, bus.event_overflow};
    endfunction

    function automatic logic [25:0] expv();
        return {2'(md_mode), (md_mode < 2), (md_mode == 2), md_sticky, 8'(md_count),
                md_valid, md_code, md_ovf};
    endfunction

    task automatic drive(input logic [7:0] bm, input logic [7:0] mk, input logic hr,
                         input logic ak, input logic rdy);
        bus.alert_bitmap = bm; bus.alert_mask = mk; bus.halt_req = hr;
        bus.ack = ak; bus.event_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(8'h00, 8'h00, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tests_run++;
        if (obs() !== 26'b00_1_0_00000000_00000000_0_0000_0) begin
            tests_failed++; $display("FAIL reset_state: got %h expected %h", obs(), 26'b00_1_0_00000000_00000000_0_0000_0);
        end
    endtask

    task automatic test_persistence();
        drive(8'h04, 8'h00, 0, 0, 0);
        tick();
        tests_run++;
        if (bus.state !== 2'd1) begin tests_failed++; $display("FAIL persist_watch1: got %0d expected 1", bus.state); end
        tick();
        tests_run++;
        if (bus.state !== 2'd1) begin tests_failed++; $display("FAIL persist_watch2: got %0d expected 1", bus.state); end
        drive(8'h00, 8'h00, 0, 0, 0);
        tick();
        tests_run++;
        if (bus.state !== 2'd0 || bus.halt_count !== 8'd0) begin
            tests_failed++; $display("FAIL persist_nohalt: state %0d count %0d expected 0 0", bus.state, bus.halt_count);
        end
        drive(8'h04, 8'h00, 0, 0, 0);
        repeat (3) tick();
        tests_run++;
        if (bus.state !== 2'd2 || bus.event_code !== 4'h2 || bus.halt_count !== 8'd1 || bus.event_valid !== 1'b1) begin
            tests_failed++; $display("FAIL persist_halt: state %0d code %h count %0d valid %b expected 2 2 1 1",
                                     bus.state, bus.event_code, bus.halt_count, bus.event_valid);
        end
        tests_run++;
        if (obs() !== expv()) begin tests_failed++; $display("FAIL persist_model: got %h expected %h", obs(), expv()); end
    endtask

    task automatic test_cooldown_exit();
        int n;
        drive(8'h00, 8'h00, 0, 1, 1);
        tick();
        drive(8'h00, 8'h00, 0, 0, 0);
        n = (bus.state == 2'd3) ? 1 : 0;
        for (int i = 0; i < 20 && bus.state == 2'd3; i++) begin
            tests_run++;
            if (bus.trade_enable !== 1'b0) begin tests_failed++; $display("FAIL cooldown_trade: got %b expected 0", bus.trade_enable); end
            tick();
            if (bus.state == 2'd3) n++;
        end
        tests_run++;
        if (n != COOLDOWN || bus.state !== 2'd0) begin
            tests_failed++; $display("FAIL cooldown_len: cycles %0d state %0d expected %0d 0", n, bus.state, COOLDOWN);
        end
        tests_run++;
        if (obs() !== expv()) begin tests_failed++; $display("FAIL cooldown_model: got %h expected %h", obs(), expv()); end
    endtask

    task automatic test_flash_mask();
        drive(8'h81, 8'h00, 0, 0, 0);
        tick();
        tests_run++;
        if (bus.state !== 2'd2 || bus.event_code !== 4'h7) begin
            tests_failed++; $display("FAIL flash_halt: state %0d code %h expected 2 7", bus.state, bus.event_code);
        end
        drive(8'h00, 8'h00, 0, 1, 1);
        tick();
        drive(8'h00, 8'h00, 0, 0, 0);
        repeat (COOLDOWN) tick();
        drive(8'h81, 8'h80, 0, 0, 0);
        tick();
        tests_run++;
        if (bus.state !== 2'd1) begin tests_failed++; $display("FAIL mask_watch: got %0d expected 1", bus.state); end
        repeat (2) tick();
        tests_run++;
        if (bus.state !== 2'd2 || bus.event_code !== 4'h0) begin
            tests_failed++; $display("FAIL mask_persist: state %0d code %h expected 2 0", bus.state, bus.event_code);
        end
        tests_run++;
        if (obs() !== expv()) begin tests_failed++; $display("FAIL mask_model: got %h expected %h", obs(), expv()); end
        drive(8'h00, 8'h00, 0, 1, 1);
        tick();
        drive(8'h00, 8'h00, 0, 0, 0);
        repeat (COOLDOWN) tick();
    endtask

    task automatic test_cooldown_retrigger();
        int n;
        int exp_cnt;
        drive(8'h80, 8'h00, 0, 0, 0);
        tick();
        drive(8'h00, 8'h00, 0, 1, 1);
        tick();
        drive(8'h00, 8'h00, 0, 0, 0);
        repeat (2) tick();
        drive(8'h02, 8'h00, 0, 0, 0);
        tick();
        drive(8'h00, 8'h00, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 20 && bus.state == 2'd3; i++) begin tick(); n++; end
        tests_run++;
        if (n != COOLDOWN || bus.state !== 2'd0) begin
            tests_failed++; $display("FAIL cooldown_reload: cycles %0d state %0d expected %0d 0", n, bus.state, COOLDOWN);
        end
        drive(8'h80, 8'h00, 0, 0, 1);
        tick();
        drive(8'h00, 8'h00, 0, 1, 1);
        tick();
        exp_cnt = md_count + 1;
        drive(8'h80, 8'h00, 0, 0, 0);
        tick();
        tests_run++;
        if (bus.state !== 2'd2 || bus.halt_count !== 8'(exp_cnt)) begin
            tests_failed++; $display("FAIL cooldown_crit: state %0d count %0d expected 2 %0d", bus.state, bus.halt_count, exp_cnt);
        end
    endtask

    task automatic test_manual_events();
        drive(8'h00, 8'h00, 0, 1, 1);
        tick();
        drive(8'h00, 8'h00, 1, 0, 0);
        tick();
        drive(8'h00, 8'h00, 1, 1, 0);
        tick();
        tests_run++;
        if (bus.state !== 2'd2 || bus.event_valid !== 1'b1 || bus.event_code !== 4'h8) begin
            tests_failed++; $display("FAIL manual_hold: state %0d valid %b code %h expected 2 1 8", bus.state, bus.event_valid, bus.event_code);
        end
        drive(8'h00, 8'h00, 0, 0, 0);
        repeat (2) tick();
        drive(8'h00, 8'h00, 0, 1, 0);
        tick();
        drive(8'h80, 8'h00, 0, 0, 0);
        tick();
        tests_run++;
        if (bus.event_overflow !== 1'b1 || bus.event_code !== 4'h8 || bus.event_valid !== 1'b1) begin
            tests_failed++; $display("FAIL event_overflow: ovf %b code %h valid %b expected 1 8 1", bus.event_overflow, bus.event_code, bus.event_valid);
        end
        drive(8'h00, 8'h00, 0, 1, 0);
        tick();
        tests_run++;
        if (bus.event_overflow !== 1'b0) begin tests_failed++; $display("FAIL ack_clear_ovf: got %b expected 0", bus.event_overflow); end
        drive(8'h80, 8'h00, 0, 0, 1);
        tick();
        tests_run++;
        if (bus.event_valid !== 1'b1 || bus.event_code !== 4'h7) begin
            tests_failed++; $display("FAIL event_ready_load: valid %b code %h expected 1 7", bus.event_valid, bus.event_code);
        end
        tests_run++;
        if (obs() !== expv()) begin tests_failed++; $display("FAIL events_model: got %h expected %h", obs(), expv()); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            drive(8'h00, 8'h00, 0, 1, 1);
            tick();
            drive(8'h00, 8'h00, 1, 0, 1);
            tick();
        end
        tests_run++;
        if (bus.halt_count !== 8'd255) begin tests_failed++; $display("FAIL saturation: got %0d expected 255", bus.halt_count); end
        tests_run++;
        if (obs() !== expv()) begin tests_failed++; $display("FAIL saturation_model: got %h expected %h", obs(), expv()); end
    endtask

    task automatic test_reset_mid();
        drive(8'h00, 8'h00, 1, 0, 0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        tests_run++;
        if (bus.state !== 2'd0 || bus.trade_enable !== 1'b1 || bus.halt_count !== 8'd0 || bus.event_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_async: state %0d trade %b count %0d valid %b expected 0 1 0 0",
                                     bus.state, bus.trade_enable, bus.halt_count, bus.event_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'h00, 8'h00, 0, 0, 0);
        tick();
        tests_run++;
        if (obs() !== expv()) begin tests_failed++; $display("FAIL reset_release: got %h expected %h", obs(), expv()); end
    endtask

    task automatic test_random();
        logic [7:0] bm;
        logic [7:0] mk;
        for (int i = 0; i < 3000; i++) begin
            bm = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
            if ($urandom_range(0, 3) != 0) bm[7] = 1'b0;
            mk = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
            drive(bm, mk, ($urandom_range(0, 29) == 0), ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
            tick();
            tests_run++;
            if (obs() !== expv()) begin
                tests_failed++; $display("FAIL random_cycle%0d: got %h expected %h", i, obs(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_persistence();
        test_cooldown_exit();
        test_flash_mask();
        test_cooldown_retrigger();
        test_manual_events();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
